// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner: captures a value in hex or decimal (double-dabble),
// then scans DIGITS common-anode positions with dp, leading-zero blank, overflow dashes and blink.
module seg_scan_display #(
  parameter int DIGITS           = 4,
  parameter int VALUE_W          = 16,
  parameter int SCAN_DIV         = 50000,
  parameter int BLINK_DIV        = 64,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               mode,
  input  logic               blank_lz,
  input  logic [DIGITS-1:0]  dp_mask,
  input  logic               blink_en,
  output logic [DIGITS-1:0]  anode,
  output logic [7:0]         digit_seg,
  output logic               busy,
  output logic               overflow
);

  localparam int BUF_W = 4 * DIGITS;
  localparam int BCD_W = 4 * (DIGITS + 1) + 1;
  localparam int EXT_W = (VALUE_W > BUF_W) ? VALUE_W : BUF_W;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(VALUE_W) + 1;
  localparam int BLK_W = $clog2(BLINK_DIV + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [VALUE_W-1:0] sh_q, sh_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLK_W-1:0]   frm_q, frm_d;
  logic               phase_q, phase_d;
  logic [DIGITS-1:0]  anode_q, anode_d;
  logic [7:0]         seg_q, seg_d;

  logic [BCD_W-1:0]   bcd_adj, bcd_shift;
  logic [EXT_W-1:0]   ext;
  logic [BUF_W-1:0]   upper;
  logic               scan_tc;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    ovf_d    = ovf_q;
    bcd_d    = bcd_q;
    sh_d     = sh_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    bcd_adj = bcd_q;
    for (int n = 0; n < DIGITS + 1; n++) begin
      if (bcd_adj[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_adj[4*n +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], sh_q[VALUE_W-1]};
    ext = EXT_W'(value);

    case (state_q)
      IDLE: begin
        if (load) begin
          if (mode) begin
            state_d  = CONV;
            sh_d     = value;
            bcd_d    = '0;
            sticky_d = 1'b0;
            cnt_d    = '0;
          end else begin
            buf_d = ext[BUF_W-1:0];
            ovf_d = |(ext >> BUF_W);
          end
        end
      end
      default: begin
        bcd_d    = bcd_shift;
        sh_d     = sh_q << 1;
        // Carry falling off the top is remembered so huge values still flag overflow.
        sticky_d = sticky_q | bcd_adj[BCD_W-1];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(VALUE_W - 1)) begin
          state_d = IDLE;
          buf_d   = bcd_shift[BUF_W-1:0];
          ovf_d   = sticky_q | bcd_adj[BCD_W-1] | (|bcd_shift[BCD_W-1:BUF_W]);
        end
      end
    endcase

    scan_tc = (div_q == DIV_W'(SCAN_DIV - 1));
    div_d   = scan_tc ? '0 : div_q + 1'b1;
    idx_d   = idx_q;
    frm_d   = frm_q;
    phase_d = phase_q;
    if (scan_tc) begin
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = '0;
        if (frm_q == BLK_W'(BLINK_DIV - 1)) begin
          frm_d   = '0;
          phase_d = ~phase_q;
        end else begin
          frm_d = frm_q + 1'b1;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // Outputs are built from the current index so each digit holds exactly SCAN_DIV cycles.
    upper = buf_q >> (4 * idx_q);
    if (ovf_q)                                     seg_d = 8'hBF;
    else if (blank_lz && idx_q != '0 && upper == '0) seg_d = 8'hFF;
    else                                           seg_d = glyph(buf_q[4*idx_q +: 4]);
    seg_d[7] = ~dp_mask[idx_q];
    if (!SEG_ACTIVE_LOW) seg_d = ~seg_d;

    anode_d = DIGITS'(1) << idx_q;
    if (blink_en && !phase_q) anode_d = '0;
    if (ANODE_ACTIVE_LOW) anode_d = ~anode_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      ovf_q    <= 1'b0;
      bcd_q    <= '0;
      sh_q     <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      frm_q    <= '0;
      phase_q  <= 1'b1;
      anode_q  <= ANODE_ACTIVE_LOW ? '1 : '0;
      seg_q    <= SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      ovf_q    <= ovf_d;
      bcd_q    <= bcd_d;
      sh_q     <= sh_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      frm_q    <= frm_d;
      phase_q  <= phase_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
    end
  end

  assign anode     = anode_q;
  assign digit_seg = seg_q;
  assign busy      = (state_q == CONV);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: a 4-digit instance (SCAN_DIV=4, BLINK_DIV=1)
// and a 2-digit instance for narrow-display overflow behaviour.
module tb_seg_scan_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] value;
  logic        load, mode, blank_lz, blink_en;
  logic [3:0]  dp_mask;
  logic [3:0]  anode;
  logic [7:0]  digit_seg;
  logic        busy, overflow;

  logic [15:0] value2;
  logic        load2, mode2, blank_lz2, blink_en2;
  logic [1:0]  dp_mask2;
  logic [1:0]  anode2;
  logic [7:0]  seg2;
  logic        busy2, ovf2;

  int checks = 0;
  int errors = 0;

  seg_scan_display #(.DIGITS(4), .VALUE_W(16), .SCAN_DIV(4), .BLINK_DIV(1),
                     .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .mode(mode),
    .blank_lz(blank_lz), .dp_mask(dp_mask), .blink_en(blink_en),
    .anode(anode), .digit_seg(digit_seg), .busy(busy), .overflow(overflow));

  seg_scan_display #(.DIGITS(2), .VALUE_W(16), .SCAN_DIV(2), .BLINK_DIV(1),
                     .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut2 (
    .clk(clk), .rst(rst), .value(value2), .load(load2), .mode(mode2),
    .blank_lz(blank_lz2), .dp_mask(dp_mask2), .blink_en(blink_en2),
    .anode(anode2), .digit_seg(seg2), .busy(busy2), .overflow(ovf2));

  task automatic get_digit(input int i, output logic [7:0] seg);
    logic [3:0] pat;
    logic       found;
    pat   = ~(4'b0001 << i);
    seg   = 8'hxx;
    found = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (!found && anode === pat) begin
        seg   = digit_seg;
        found = 1'b1;
      end
      if (found) n = 64;
    end
  endtask

  task automatic get_digit2(input int i, output logic [7:0] seg);
    logic [1:0] pat;
    logic       found;
    pat   = ~(2'b01 << i);
    seg   = 8'hxx;
    found = 1'b0;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      if (!found && anode2 === pat) begin
        seg   = seg2;
        found = 1'b1;
      end
      if (found) n = 32;
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic m);
    @(negedge clk);
    value = v; mode = m; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      if (busy) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (anode !== 4'b1111) begin errors++; $display("FAIL reset_anode: got %b expected 1111", anode); end
    checks++; if (digit_seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h expected FF", digit_seg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((c / 4) % 4));
      checks++;
      if (anode !== exp_an) begin errors++; $display("FAIL scan_c%0d: got %b expected %b", c, anode, exp_an); end
    end
    checks++; if (digit_seg !== 8'hC0) begin errors++; $display("FAIL reset_zero_glyph: got %h expected C0", digit_seg); end
  endtask

  task automatic test_hex();
    logic [7:0] exp_seg [4];
    logic [7:0] got;
    exp_seg = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
    blank_lz = 1'b0;
    pulse_load(16'h12AF, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hex_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL hex_ovf: got %b expected 0", overflow); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      get_digit(i, got);
      checks++;
      if (got !== exp_seg[i]) begin errors++; $display("FAIL hex_d%0d: got %h expected %h", i, got, exp_seg[i]); end
    end
  endtask

  task automatic test_decimal();
    logic [7:0] exp_seg [4];
    logic [7:0] got;
    int bcount;
    exp_seg = '{8'hF8, 8'h80, 8'hFF, 8'hFF};
    blank_lz = 1'b1;
    pulse_load(16'd87, 1'b1);
    bcount = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy) bcount++;
      @(negedge clk);
    end
    checks++; if (bcount != 16) begin errors++; $display("FAIL dec_busy_cycles: got %0d expected 16", bcount); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dec_ovf: got %b expected 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      get_digit(i, got);
      checks++;
      if (got !== exp_seg[i]) begin errors++; $display("FAIL dec_d%0d: got %h expected %h", i, got, exp_seg[i]); end
    end
  endtask

  task automatic test_overflow_dp();
    logic [7:0] got;
    logic [7:0] exp;
    pulse_load(16'd12345, 1'b1);
    wait_idle();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL dec_ovf_12345: got %b expected 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      get_digit(i, got);
      checks++;
      if (got !== 8'hBF) begin errors++; $display("FAIL ovf_d%0d: got %h expected BF", i, got); end
    end
    dp_mask = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      exp = (i == 2) ? 8'h3F : 8'hBF;
      get_digit(i, got);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL dp_d%0d: got %h expected %h", i, got, exp); end
    end
    dp_mask = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seg [4];
    logic [7:0] got;
    exp_seg = '{8'hF8, 8'h80, 8'hFF, 8'hFF};
    blank_lz = 1'b1;
    pulse_load(16'd87, 1'b1);
    repeat (3) @(negedge clk);
    value = 16'd12345; mode = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b expected 0", busy); end
    for (int i = 0; i < 4; i++) begin
      get_digit(i, got);
      checks++;
      if (got !== exp_seg[i]) begin errors++; $display("FAIL b2b_d%0d: got %h expected %h", i, got, exp_seg[i]); end
    end
  endtask

  task automatic test_narrow();
    logic [7:0] got;
    @(negedge clk);
    value2 = 16'h0033; mode2 = 1'b0; load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL narrow_ovf_33: got %b expected 0", ovf2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL narrow_busy: got %b expected 0", busy2); end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      get_digit2(i, got);
      checks++;
      if (got !== 8'hB0) begin errors++; $display("FAIL narrow_d%0d: got %h expected B0", i, got); end
    end
    value2 = 16'h0133; load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    checks++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL narrow_ovf_133: got %b expected 1", ovf2); end
    @(negedge clk);
    get_digit2(1, got);
    checks++; if (got !== 8'hBF) begin errors++; $display("FAIL narrow_dash: got %h expected BF", got); end
  endtask

  task automatic test_blink();
    int off_cnt;
    int bad_cnt;
    blink_en = 1'b1;
    off_cnt = 0; bad_cnt = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (anode === 4'b1111) off_cnt++;
      else if (!(anode === 4'b1110 || anode === 4'b1101 || anode === 4'b1011 || anode === 4'b0111)) bad_cnt++;
    end
    checks++; if (off_cnt != 32) begin errors++; $display("FAIL blink_off_cycles: got %0d expected 32", off_cnt); end
    checks++; if (bad_cnt != 0) begin errors++; $display("FAIL blink_bad_anode: got %0d expected 0", bad_cnt); end
    blink_en = 1'b0;
    off_cnt = 0;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      if (anode === 4'b1111) off_cnt++;
    end
    checks++; if (off_cnt != 0) begin errors++; $display("FAIL noblink_off_cycles: got %0d expected 0", off_cnt); end
  endtask

  task automatic test_reset_mid_conv();
    logic [7:0] got;
    blank_lz = 1'b0;
    pulse_load(16'd999, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midconv_busy: got %b expected 1", busy); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (digit_seg !== 8'hFF) begin errors++; $display("FAIL rstmid_seg: got %h expected FF", digit_seg); end
    checks++; if (anode !== 4'b1111) begin errors++; $display("FAIL rstmid_anode: got %b expected 1111", anode); end
    @(negedge clk);
    rst = 1'b0;
    get_digit(1, got);
    checks++; if (got !== 8'hC0) begin errors++; $display("FAIL rstmid_buf_lost: got %h expected C0", got); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b expected 0", overflow); end
  endtask

  initial begin
    rst = 1'b1;
    value = '0; load = 1'b0; mode = 1'b0; blank_lz = 1'b0; dp_mask = '0; blink_en = 1'b0;
    value2 = '0; load2 = 1'b0; mode2 = 1'b0; blank_lz2 = 1'b0; dp_mask2 = '0; blink_en2 = 1'b0;
    test_reset();
    test_hex();
    test_decimal();
    test_overflow_dp();
    test_back_to_back();
    test_narrow();
    test_blink();
    test_reset_mid_conv();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multiplexed seven-segment scanner that replaces the fixed 4-digit, 8-bit score display. It captures a binary value on a load strobe and renders it in hex, or in decimal via a sequential double-dabble converter. It then time-multiplexes DIGITS common-anode positions with per-digit decimal points, leading-zero blanking, overflow indication and whole-display blink. It sits between game/score logic and the board's anode/segment pins.

## Interface
- DIGITS, 4: number of multiplexed digit positions (1..8)
- VALUE_W, 16: width of the binary input value
- SCAN_DIV, 50000: clk cycles each digit stays selected (≥2)
- BLINK_DIV, 64: full scan frames per blink half-period (≥1)
- ANODE_ACTIVE_LOW, 1: 1 = anode drive is active-low
- SEG_ACTIVE_LOW, 1: 1 = segment drive is active-low
- clk  in  1  system clock, single domain
- rst  in  1  asynchronous, active-high reset
- value  in  VALUE_W  binary value to display, sampled on load
- load  in  1  one-cycle capture strobe
- mode  in  1  sampled with load; 0 = hex, 1 = decimal
- blank_lz  in  1  1 = blank leading zero digits (digit 0 never blanked)
- dp_mask  in  DIGITS  decimal-point enable per digit, live (not latched)
- blink_en  in  1  1 = blink whole display
- anode  out  DIGITS  one-hot digit select, polarity per ANODE_ACTIVE_LOW
- digit_seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- busy  out  1  decimal conversion in progress
- overflow  out  1  last captured value not representable in DIGITS digits

## Operation
- Two-state control FSM: IDLE, CONV. load is accepted only in IDLE; load while busy is dropped, with no queueing.
- Hex capture: digit i = value[4i+3:4i], zero-extended past VALUE_W. overflow = any value bit at or above 4*DIGITS.
- Decimal capture: the FSM enters CONV and runs a double-dabble over VALUE_W iterations, one bit per cycle (add 3 to each BCD nibble ≥5, then shift).
  - The BCD register is DIGITS+1 nibbles wide plus carry. overflow = any bit beyond DIGITS nibbles is nonzero.
- The digit buffer and overflow are updated atomically at completion. The buffer never shows partial conversion results.
- Overflow display: every digit shows a dash (segment g only). Blanking is ignored while overflow is set. dp_mask still applies.
- Leading-zero blank: with blank_lz=1, every digit above the highest nonzero digit shows all segments off. dp still applies.
- Glyphs: 0-9, A, b, C, d, E, F. Active-low codes with dp off: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E. dp is bit 7, cleared (active-low) when dp_mask[i]=1.
- Scan: a divider counts 0..SCAN_DIV-1. At the terminal count, the digit index advances, wrapping DIGITS-1 to 0.
- Blink: a frame counter toggles the blink phase every BLINK_DIV frames; the phase resets to on. With blink_en=1 and phase off, all anodes are inactive. The counters run regardless of blink_en.

## Timing
- Reset (async assert) values:
  - anode all inactive; digit_seg all off (8'hFF active-low)
  - busy=0, overflow=0
  - digit buffer all zero; scan index 0; divider 0; blink phase on
- First rising edge after reset release: anode selects digit 0, showing buffer digit 0.
- anode and digit_seg are both registered and change on the same edge, so there is no ghosting cycle.
- Each digit is active for exactly SCAN_DIV cycles; a frame is DIGITS*SCAN_DIV cycles.
- Hex load sampled at edge k: buffer and overflow are updated at edge k, visible on digit_seg at edge k+1 if that digit is selected. busy stays 0.
- Decimal load at edge k: busy=1 after edge k. Iterations run on edges k+1..k+VALUE_W. Buffer and overflow are updated and busy=0 after edge k+VALUE_W. A new load is accepted from edge k+VALUE_W+1.
- dp_mask, blank_lz and blink_en are applied at the next digit_seg/anode register update.
- Reset mid-conversion: the conversion is aborted, all reset values apply immediately, and the old buffer is lost.

## Test plan
- Reset, DIGITS=4, SCAN_DIV=4, both polarities low -> anode=4'b1111, digit_seg=8'hFF. After release: anode 1110, 1101, 1011, 0111, each for 4 cycles, then wrap.
- Hex load 16'h12AF, blank_lz=0 -> digit0..3 = 8E, 88, A4, F9; busy never 1; overflow=0.
- Decimal load 16'd87, blank_lz=1 -> busy high exactly 16 cycles; then digit0=F8, digit1=80, digit2=FF, digit3=FF.
- Decimal load 16'd12345 -> overflow=1, all digits BF. Hex load 8'h33 with VALUE_W=16, DIGITS=2 -> overflow=0, digits B0 B0.
- Second load 4 cycles into a conversion -> ignored, and the result is from the first value. dp_mask=4'b0100 -> digit2 bit7=0 only.
- BLINK_DIV=1, blink_en=1 -> anodes all 1111 on alternate frames. Assert rst mid-conversion -> busy=0, digit_seg=FF within the same cycle.
